// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: settle/run/report run controller with prioritised termination; SIM_RUN_CTRL_LCE_ALARM_EN adds lce_alarm_i
module sim_run_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] max_cycles_i,
  input  logic                 tests_passed_i,
  input  logic                 tests_failed_i,
  input  logic                 exit_valid_i,
  input  logic [31:0]          exit_value_i,
`ifdef SIM_RUN_CTRL_LCE_ALARM_EN
  input  logic                 lce_alarm_i,
`endif
  input  logic [PC_WIDTH-1:0]  pc_if_i,
  input  logic                 instr_valid_i,
  output logic                 fetch_enable_o,
  output logic                 running_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [2:0]           result_reason_o,
  output logic [CNT_WIDTH-1:0] result_cycle_o,
  output logic [PC_WIDTH-1:0]  result_pc_o,
  output logic [31:0]          result_exit_value_o,
  output logic [CNT_WIDTH-1:0] result_instr_cnt_o,
  output logic                 done_o
);
  typedef enum logic [2:0] {IDLE, SETTLE, RUN, REPORT, DONE} state_e;
  state_e state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic [CNT_WIDTH-1:0] res_cycle_q, res_cycle_d, res_instr_q, res_instr_d;
  logic [PC_WIDTH-1:0] res_pc_q, res_pc_d;
  logic [31:0] res_exit_q, res_exit_d;
  logic [2:0] reason_q, reason_d, reason_sel;
  logic alarm, go, term;
`ifdef SIM_RUN_CTRL_LCE_ALARM_EN
  assign alarm = lce_alarm_i;
`else
  assign alarm = 1'b0;
`endif
  always_comb begin
    go = start_i && (state_q == IDLE || state_q == DONE);
    reason_sel = alarm ? 3'd6 :
                 tests_failed_i ? 3'd2 :
                 (exit_valid_i && exit_value_i != '0) ? 3'd4 :
                 tests_passed_i ? 3'd1 :
                 exit_valid_i ? 3'd3 :
                 (max_cycles_i != '0 && cycle_q >= max_cycles_i) ? 3'd5 : 3'd0;
    term = state_q == RUN && reason_sel != 3'd0;
    state_d = go ? SETTLE :
              (state_q == SETTLE && settle_q == '0) ? RUN :
              term ? REPORT :
              (state_q == REPORT && result_ready_i) ? DONE : state_q;
    settle_d = go ? 8'(SETTLE_CYCLES) : (state_q == SETTLE && settle_q != '0) ? settle_q - 8'd1 : settle_q;
    cycle_d = go ? '0 : (state_q == RUN && !term && cycle_q != '1) ? cycle_q + CNT_WIDTH'(1) : cycle_q;
    instr_d = go ? '0 : (state_q == RUN && !term && instr_valid_i && instr_q != '1) ? instr_q + CNT_WIDTH'(1) : instr_q;
    reason_d = go ? '0 : term ? reason_sel : reason_q;
    res_cycle_d = go ? '0 : term ? cycle_q : res_cycle_q;
    res_instr_d = go ? '0 : term ? instr_q : res_instr_q;
    res_pc_d = go ? '0 : term ? pc_if_i : res_pc_q;
    res_exit_d = go ? '0 : (term && reason_sel == 3'd4) ? exit_value_i : term ? '0 : res_exit_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      settle_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
      reason_q <= '0;
      res_cycle_q <= '0;
      res_instr_q <= '0;
      res_pc_q <= '0;
      res_exit_q <= '0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      reason_q <= reason_d;
      res_cycle_q <= res_cycle_d;
      res_instr_q <= res_instr_d;
      res_pc_q <= res_pc_d;
      res_exit_q <= res_exit_d;
    end
  end
  assign fetch_enable_o = state_q == RUN;
  assign running_o = state_q == RUN;
  assign result_valid_o = state_q == REPORT;
  assign done_o = state_q == DONE;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;
  assign result_reason_o = reason_q;
  assign result_cycle_o = res_cycle_q;
  assign result_pc_o = res_pc_q;
  assign result_exit_value_o = res_exit_q;
  assign result_instr_cnt_o = res_instr_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: randomized scoreboard bench for sim_run_ctrl
module tb_sim_run_ctrl;
  localparam int ST = 2;
`ifdef SIM_RUN_CTRL_LCE_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] max_cycles = '0, exit_value = '0, pc_if = '0;
  logic passed = 1'b0, failed = 1'b0, exit_valid = 1'b0, alarm = 1'b0, instr_valid = 1'b0, ready = 1'b0;
  logic fetch_en, running, res_valid, done;
  logic [31:0] cycle_cnt, instr_cnt, res_cycle, res_pc, res_exit, res_instr;
  logic [2:0] res_reason;
  typedef struct {logic [2:0] reason; logic [31:0] cyc, pc, xv, ni;} rec_t;
  rec_t sbq[$];
  rec_t e;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  sim_run_ctrl #(.SETTLE_CYCLES(ST), .CNT_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .max_cycles_i(max_cycles),
    .tests_passed_i(passed), .tests_failed_i(failed), .exit_valid_i(exit_valid), .exit_value_i(exit_value),
`ifdef SIM_RUN_CTRL_LCE_ALARM_EN
    .lce_alarm_i(alarm),
`endif
    .pc_if_i(pc_if), .instr_valid_i(instr_valid), .fetch_enable_o(fetch_en), .running_o(running),
    .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt), .result_valid_o(res_valid), .result_ready_i(ready),
    .result_reason_o(res_reason), .result_cycle_o(res_cycle), .result_pc_o(res_pc),
    .result_exit_value_o(res_exit), .result_instr_cnt_o(res_instr), .done_o(done)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_total++;
    if (a !== x) $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    else n_pass++;
  endtask
  function automatic logic [2:0] ref_reason(input bit al, input bit f, input bit x, input logic [31:0] xv,
                                            input bit p, input int k, input logic [31:0] mx);
    if (al && ALARM_EN) return 3'd6;
    if (f) return 3'd2;
    if (x && xv != 0) return 3'd4;
    if (p) return 3'd1;
    if (x) return 3'd3;
    if (mx != 0 && 32'(k) >= mx) return 3'd5;
    return 3'd0;
  endfunction
  always @(negedge clk) begin
    #2;
    if (rst_n && res_valid) begin
      if (sbq.size() == 0) chk("sb_unexpected_valid", 1, 0);
      else begin
        e = sbq[0];
        chk("reason", 64'(res_reason), 64'(e.reason));
        chk("res_cycle", 64'(res_cycle), 64'(e.cyc));
        chk("res_pc", 64'(res_pc), 64'(e.pc));
        chk("res_exit", 64'(res_exit), 64'(e.xv));
        chk("res_instr", 64'(res_instr), 64'(e.ni));
        if (ready) void'(sbq.pop_front());
      end
    end
  end
  task automatic start_and_wait(output bit ok);
    int w;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_clears_reason", 64'(res_reason), 0);
    w = 1;
    while (!fetch_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("settle_len", 64'(w), 64'(ST + 2));
    chk("run_cycle0", 64'(cycle_cnt), 0);
    chk("run_instr0", 64'(instr_cnt), 0);
    ok = fetch_en;
  endtask
  task automatic do_run(input int tk, input logic [3:0] ev, input logic [31:0] xv, input logic [31:0] mx,
                        input int lk, input logic [31:0] lv, input int rdy_wait, input bit preready,
                        input logic [31:0] pcfix, input int n_iv);
    bit ok, fin;
    int k, ni;
    logic [2:0] r;
    max_cycles = mx;
    start_and_wait(ok);
    if (!ok) return;
    k = 0;
    ni = 0;
    fin = 0;
    ready = preready;
    while (!fin && k < 200) begin
      max_cycles = (k >= lk) ? lv : mx;
      pc_if = (k == tk && pcfix != 0) ? pcfix : $urandom;
      instr_valid = (n_iv >= 0) ? (k < n_iv) : 1'($urandom_range(0, 1));
      passed = (k == tk) && ev[0];
      failed = (k == tk) && ev[1];
      exit_valid = (k == tk) && ev[2];
      alarm = (k == tk) && ev[3];
      exit_value = (k == tk) ? xv : $urandom;
      r = ref_reason(alarm, failed, exit_valid, exit_value, passed, k, max_cycles);
      if (r != 0) begin
        sbq.push_back('{r, 32'(k), pc_if, (r == 3'd4) ? exit_value : 32'd0, 32'(ni)});
        fin = 1;
      end else ni += int'(instr_valid);
      @(negedge clk);
      k++;
    end
    {passed, failed, exit_valid, alarm, instr_valid} = '0;
    chk("latency_valid", 64'(res_valid), 1);
    chk("latency_fetch_off", 64'(fetch_en), 0);
    if (!preready) begin
      repeat (rdy_wait) @(negedge clk);
      ready = 1'b1;
    end
    @(negedge clk);
    chk("done_after_accept", 64'({done, res_valid}), 64'(2'b10));
    ready = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit ok;
    logic [3:0] ev;
    logic [31:0] mx;
    int tk;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(|{fetch_en, running, cycle_cnt, instr_cnt, res_valid, res_reason, res_cycle,
                               res_pc, res_exit, res_instr, done}), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) {passed, failed, exit_valid, alarm} = 4'hf;
      exit_value = 32'h5;
      chk("idle_ignores_events", 64'({fetch_en, running, res_valid, done}), 0);
    end
    @(negedge clk) {passed, failed, exit_valid, alarm} = '0;
    do_run(1000, 4'b0000, 0, 32'd10, 1000, 0, 4, 1'b0, 0, -1);
    do_run(4, 4'b0101, 32'd7, 0, 1000, 0, 1, 1'b0, 0, -1);
    do_run(25, 4'b0010, 0, 0, 1000, 0, 0, 1'b0, 32'h180, 12);
    do_run(5, 4'b1001, 0, 0, 1000, 0, 2, 1'b0, 0, -1);
    do_run(5, 4'b0001, 0, 0, 1000, 0, 2, 1'b0, 0, -1);
    do_run(1000, 4'b0000, 0, 32'd50, 20, 32'd8, 0, 1'b0, 0, -1);
    do_run(3, 4'b0100, 0, 0, 1000, 0, 0, 1'b1, 0, -1);
    start_and_wait(ok);
    pc_if = 32'h44;
    passed = 1'b1;
    sbq.push_back('{3'd1, 32'd0, 32'h44, 32'd0, 32'd0});
    @(negedge clk) passed = 1'b0;
    chk("pre_reset_valid", 64'(res_valid), 1);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'(|{fetch_en, running, cycle_cnt, instr_cnt, res_valid, res_reason, res_cycle,
                                        res_pc, res_exit, res_instr, done}), 0);
    sbq.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int r = 0; r < 12; r++) begin
      ev = 4'($urandom_range(0, 15));
      tk = $urandom_range(0, 30);
      mx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      if (mx == 0 && (ev & (ALARM_EN ? 4'hf : 4'h7)) == 0) mx = 35;
      do_run(tk, ev, ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom, mx, 1000, 0,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, -1);
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Synthesizable run controller for the cv32e40p verilator bench.
- Starts the core after a settle delay and counts run cycles and retired instructions.
- Arbitrates all termination sources (pass, fail, exit, cycle limit, optional LCE alarm) with fixed priority.
- Freezes the final cycle, PC and reason into a result record. The record is offered to the bench logger over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, cycles spent in SETTLE after start before fetch enable rises (valid range 0..255)
CNT_WIDTH, 32, width of the cycle and instruction counters
PC_WIDTH, 32, width of the sampled fetch PC

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start pulse; honoured in IDLE and DONE only
max_cycles_i  in  CNT_WIDTH  cycle limit; 0 = no limit; sampled continuously
tests_passed_i  in  1  pass flag from the bench wrapper
tests_failed_i  in  1  fail flag from the bench wrapper
exit_valid_i  in  1  exit strobe
exit_value_i  in  32  exit code, qualified by exit_valid_i
pc_if_i  in  PC_WIDTH  IF-stage PC
instr_valid_i  in  1  IF→ID instruction valid
fetch_enable_o  out  1  core fetch enable
running_o  out  1  high in RUN
cycle_cnt_o  out  CNT_WIDTH  live cycle counter
instr_cnt_o  out  CNT_WIDTH  live instruction counter
result_valid_o  out  1  result record valid
result_ready_i  in  1  logger accepts record
result_reason_o  out  3  termination reason code
result_cycle_o  out  CNT_WIDTH  cycle count at termination
result_pc_o  out  PC_WIDTH  PC at termination
result_exit_value_o  out  32  exit code (0 unless reason 3/4)
result_instr_cnt_o  out  CNT_WIDTH  instruction count at termination
done_o  out  1  high in DONE

Behaviour:
- Reset: state IDLE. All outputs 0. All counters and result registers 0. Settle counter 0.
- States and transitions:
  - IDLE: on start_i → SETTLE. Counters cleared. Settle counter loaded with SETTLE_CYCLES.
  - SETTLE: settle counter decrements each cycle. When it is 0 → RUN, fetch_enable_o=1 from the next cycle. SETTLE_CYCLES=0 spends exactly 1 cycle in SETTLE.
  - RUN: running_o=1.
    - cycle_cnt increments every cycle, saturating at all-ones.
    - instr_cnt increments when instr_valid_i=1, saturating.
    - Termination inputs are evaluated every cycle.
    - On any termination: capture reason, the pre-increment cycle_cnt, pc_if_i, instr_cnt (excluding this cycle's instr_valid_i) and exit_value_i → REPORT.
  - REPORT: fetch_enable_o=0 and result_valid_o=1. The record is stable until result_valid_o & result_ready_i → DONE. Counters are frozen.
  - DONE: done_o=1. start_i → SETTLE; the previous result is cleared on that transition.
- Reason codes and priority when several sources are simultaneous (highest first):
  - 6 LCE alarm
  - 2 tests failed
  - 4 exit with nonzero value
  - 1 tests passed
  - 3 exit with value 0
  - 5 cycle limit: max_cycles_i≠0 and cycle_cnt ≥ max_cycles_i
  - Code 0 = none; it never appears with result_valid_o=1. Code 7 is unused.
- Latency: a termination input in RUN cycle N gives result_valid_o=1 and fetch_enable_o=0 at cycle N+1.
- Termination inputs are ignored outside RUN. start_i is ignored in SETTLE, RUN and REPORT.
- If result_ready_i is already high on REPORT entry, REPORT lasts exactly one cycle.
- If max_cycles_i is lowered below cycle_cnt during RUN, termination reason 5 fires on the next evaluation.
- Asynchronous reset mid-operation returns the block to IDLE immediately. Any pending record is discarded.

Optional Feature:
Macro SIM_RUN_CTRL_LCE_ALARM_EN.
- Defined: adds input port lce_alarm_i (1 bit). lce_alarm_i=1 in RUN terminates with reason 6 at highest priority.
- Undefined: the port is absent and reason 6 is never produced. All other behaviour is identical.

Test Plan:
1. Reset, start_i pulse, SETTLE_CYCLES=2 → fetch_enable_o rises 3 cycles after start; cycle_cnt_o=0 on first RUN cycle.
2. max_cycles_i=10, no other events → result_reason_o=5, result_cycle_o=10; result_valid_o held with result_ready_i=0 for 4 cycles and record stable; ready=1 → DONE next cycle.
3. tests_passed_i and exit_valid_i with exit_value_i=7 in same RUN cycle → reason 4, result_exit_value_o=7.
4. tests_failed_i at cycle 25 with pc_if_i=0x0000_0180, 12 instr_valid_i pulses before it → reason 2, result_cycle_o=25, result_pc_o=0x180, result_instr_cnt_o=12.
5. With SIM_RUN_CTRL_LCE_ALARM_EN: lce_alarm_i and tests_passed_i together at cycle 5 → reason 6, result_cycle_o=5. Without the macro, the same stimulus minus the alarm → reason 1.
6. rst_ni low during REPORT → all outputs 0 immediately. Events asserted in IDLE are ignored. start_i in DONE restarts with cleared counters.
